n108_bank_core: RTL and testbench
=================================

N108_BANK_CORE -- requirements
Module: n108_bank_core

Interface
REQ-001 SHALL have parameter PRG_W, default 6, width of an 8 KB PRG page number.
REQ-002 SHALL have parameter CHR_W, default 8, width of a 1 KB CHR page number.
REQ-003 SHALL have parameter A12_FILT, default 3, minimum consecutive clk cycles with A12 low before a rising edge counts.
REQ-004 SHALL have port clk, input, 1, single clock: one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port cpu_we, input, 1, one-cycle strobe per CPU write.
REQ-007 SHALL have port cpu_addr, input, 16, CPU address.
REQ-008 SHALL have port cpu_data, input, 8, CPU write data.
REQ-009 SHALL have port ppu_addr, input, 3, PPU A12..A10.
REQ-010 SHALL have port prg_page, output, PRG_W, page for current cpu_addr[14:13].
REQ-011 SHALL have port chr_page, output, CHR_W, page for current ppu_addr.
REQ-012 SHALL have port mirror, output, 1, 0 = vertical, 1 = horizontal.
REQ-013 SHALL have port wram_ctl, output, 2, bit1 = WRAM enable, bit0 = write protect.
REQ-014 SHALL have port irq, output, 1, active-high level IRQ.

Function
REQ-015 Writes SHALL be decoded only when cpu_we=1 and cpu_addr[15]=1, using cpu_addr[14:13] and cpu_addr[0].
REQ-016 $8000 even SHALL load sel: [2:0] register index, [6] PRG mode, [7] CHR invert.
REQ-017 $8000 odd SHALL load bank[idx]: idx 0-5 take low CHR_W bits, idx 6-7 take low PRG_W bits; bit0 of bank0/bank1 is stored but ignored on output.
REQ-018 $A000 even SHALL load mirror <= data[0]; $A000 odd SHALL load wram_ctl <= data[7:6].
REQ-019 PRG map, mode 0: slot0 = R6, slot1 = R7, slot2 = all-ones-minus-1, slot3 = all-ones. Mode 1: slot0 and slot2 are swapped; slots 1 and 3 are unchanged.
REQ-020 CHR map: with q = ppu_addr[12:10] XOR {invert,0,0}, q=0/1 SHALL give {R0[CHR_W-1:1],q[0]}, q=2/3 SHALL give {R1[CHR_W-1:1],q[0]}, and q=4..7 SHALL give R2..R5.
REQ-021 prg_page and chr_page SHALL be combinational from the registers and the address, with zero latency.
REQ-022 $C000 even SHALL load latch <= data; $C000 odd SHALL set reload and clear counter.
REQ-023 $E000 even SHALL clear irq_en and irq; $E000 odd SHALL set irq_en.
REQ-024 A counted A12 edge is a 0->1 transition on ppu_addr[2], sampled on clk, preceded by at least A12_FILT low samples; the low-run counter SHALL saturate.
REQ-025 On a counted edge: if counter==0 or reload=1, counter <= latch and reload <= 0; otherwise counter <= counter-1.
REQ-026 If the counter value after the update is 0 and irq_en=1, irq SHALL assert on the next clk edge and hold until the $E000-even write.
REQ-027 If a $C000-odd or $E000 write coincides with a counted edge, the write SHALL win and the edge SHALL be discarded.
REQ-028 latch=0 SHALL fire irq on every counted edge while irq_en=1.

Reset
REQ-029 rst_n low SHALL asynchronously clear bank[0..7], sel, mirror, wram_ctl, latch, counter, reload, irq_en, irq and the filter state to 0.
REQ-030 Reset asserted mid-count SHALL abort the count; the first edge after release SHALL load latch (counter==0).

Configuration
REQ-031 With N108_SCANLINE_IRQ_EN defined, REQ-022 to REQ-028 SHALL be implemented.
REQ-032 Without N108_SCANLINE_IRQ_EN, irq SHALL be tied 0, $C000 and $E000 writes SHALL be ignored, and no counter or filter logic SHALL be present.

Structure
REQ-033 The shared package SHALL hold the register-index constants (R0..R7), the sel bit positions and the write-decode address constants.
REQ-034 The A12 filter and edge detector SHALL be the sub-module n108_a12_filter, parametrised by A12_FILT, outputting a one-cycle edge pulse.

Verification
REQ-035 Write $8000=06, $8001=05, $8000=07, $8001=09 -> cpu_addr $8000 gives prg_page 5, $A000 gives 9, $C000 gives 62, $E000 gives 63.
REQ-036 Write $8000=46 -> cpu_addr $8000 gives prg_page 62 and $C000 gives 5.
REQ-037 Write $8000=80, $8001=10, then drive ppu_addr=3'b100 -> chr_page 16; ppu_addr=3'b101 -> 17.
REQ-038 latch=2, $C001, $E001, then three filtered A12 edges -> counter 2,1,0; irq rises one clk after the third edge and clears on a $E000 write.
REQ-039 An A12 pulse with only A12_FILT-1 low cycles before it -> no count. A $C001 write in the same cycle as an edge -> counter stays 0 and reload stays 1.
REQ-040 Assert rst_n mid-count with irq high -> all outputs 0 immediately; a build without N108_SCANLINE_IRQ_EN keeps irq=0 under the REQ-038 stimulus.

Source files
------------

// File: rtl/n108_bank_core_pkg.sv
// Shared constants for the N108 bank core: register indices, select-byte fields and write decode.
package n108_bank_core_pkg;

  localparam logic [2:0] R0 = 3'd0;
  localparam logic [2:0] R1 = 3'd1;
  localparam logic [2:0] R2 = 3'd2;
  localparam logic [2:0] R3 = 3'd3;
  localparam logic [2:0] R4 = 3'd4;
  localparam logic [2:0] R5 = 3'd5;
  localparam logic [2:0] R6 = 3'd6;
  localparam logic [2:0] R7 = 3'd7;

  localparam int unsigned SelIdxLsb  = 0;
  localparam int unsigned SelIdxMsb  = 2;
  localparam int unsigned SelPrgMode = 6;
  localparam int unsigned SelChrInv  = 7;

  // cpu_addr[15] enables decode, [14:13] picks the window, [0] picks even/odd register.
  localparam int unsigned AddrEnBit  = 15;
  localparam int unsigned AddrWinMsb = 14;
  localparam int unsigned AddrWinLsb = 13;
  localparam int unsigned AddrOddBit = 0;

  typedef enum logic [1:0] {
    WinBank     = 2'b00,  // $8000
    WinMirror   = 2'b01,  // $A000
    WinIrqLatch = 2'b10,  // $C000
    WinIrqCtl   = 2'b11   // $E000
  } win_e;

endpackage

// File: rtl/n108_a12_filter.sv
// PPU A12 rise detector: a rise counts only after at least A12_FILT consecutive low samples.
module n108_a12_filter #(
  parameter int unsigned A12_FILT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a12,
  output logic a12_rise
);

  localparam int unsigned CntW = (A12_FILT < 1) ? 1 : $clog2(A12_FILT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(A12_FILT);

  logic [CntW-1:0] low_cnt_q, low_cnt_d;
  logic            a12_q;

  always_comb begin
    low_cnt_d = low_cnt_q;
    if (a12) begin
      low_cnt_d = '0;
    end else if (low_cnt_q != CntMax) begin
      low_cnt_d = low_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low_cnt_q <= '0;
      a12_q     <= 1'b0;
    end else begin
      low_cnt_q <= low_cnt_d;
      a12_q     <= a12;
    end
  end

  assign a12_rise = a12 & ~a12_q & (low_cnt_q >= CntMax);

endmodule

// File: rtl/n108_bank_core.sv
// N108 PRG/CHR bank mapper. Define N108_SCANLINE_IRQ_EN to build the A12 scanline IRQ counter.
module n108_bank_core
  import n108_bank_core_pkg::*;
#(
  parameter int unsigned PRG_W    = 6,
  parameter int unsigned CHR_W    = 8,
  parameter int unsigned A12_FILT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_we,
  input  logic [15:0]      cpu_addr,
  input  logic [7:0]       cpu_data,
  input  logic [2:0]       ppu_addr,
  output logic [PRG_W-1:0] prg_page,
  output logic [CHR_W-1:0] chr_page,
  output logic             mirror,
  output logic [1:0]       wram_ctl,
  output logic             irq
);

  localparam logic [PRG_W-1:0] PrgLast       = '1;
  localparam logic [PRG_W-1:0] PrgSecondLast = {{(PRG_W-1){1'b1}}, 1'b0};

  logic [CHR_W-1:0] chr_bank_q [0:5];
  logic [PRG_W-1:0] prg_bank_q [0:1];
  logic [2:0]       sel_idx_q;
  logic             prg_mode_q, chr_inv_q, mirror_q;
  logic [1:0]       wram_ctl_q;

  logic wr_en, odd;
  win_e win;
  assign wr_en = cpu_we & cpu_addr[AddrEnBit];
  assign win   = win_e'(cpu_addr[AddrWinMsb:AddrWinLsb]);
  assign odd   = cpu_addr[AddrOddBit];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) chr_bank_q[i] <= '0;
      prg_bank_q[0] <= '0;
      prg_bank_q[1] <= '0;
      sel_idx_q     <= '0;
      prg_mode_q    <= 1'b0;
      chr_inv_q     <= 1'b0;
      mirror_q      <= 1'b0;
      wram_ctl_q    <= '0;
    end else if (wr_en) begin
      case (win)
        WinBank: begin
          if (!odd) begin
            sel_idx_q  <= cpu_data[SelIdxMsb:SelIdxLsb];
            prg_mode_q <= cpu_data[SelPrgMode];
            chr_inv_q  <= cpu_data[SelChrInv];
          end else begin
            for (int i = 0; i < 6; i++) begin
              if (sel_idx_q == 3'(i)) chr_bank_q[i] <= cpu_data[CHR_W-1:0];
            end
            if (sel_idx_q == R6) prg_bank_q[0] <= cpu_data[PRG_W-1:0];
            if (sel_idx_q == R7) prg_bank_q[1] <= cpu_data[PRG_W-1:0];
          end
        end
        WinMirror: begin
          if (!odd) mirror_q <= cpu_data[0];
          else      wram_ctl_q <= cpu_data[7:6];
        end
        default: ;
      endcase
    end
  end

  // Mode 1 swaps the fixed second-last page with R6 between slots 0 and 2.
  always_comb begin
    case (cpu_addr[AddrWinMsb:AddrWinLsb])
      2'd0:    prg_page = prg_mode_q ? PrgSecondLast : prg_bank_q[0];
      2'd1:    prg_page = prg_bank_q[1];
      2'd2:    prg_page = prg_mode_q ? prg_bank_q[0] : PrgSecondLast;
      default: prg_page = PrgLast;
    endcase
  end

  logic [2:0] chr_q;
  assign chr_q = ppu_addr ^ {chr_inv_q, 2'b00};

  always_comb begin
    case (chr_q)
      3'd0, 3'd1: chr_page = {chr_bank_q[R0][CHR_W-1:1], chr_q[0]};
      3'd2, 3'd3: chr_page = {chr_bank_q[R1][CHR_W-1:1], chr_q[0]};
      3'd4:       chr_page = chr_bank_q[R2];
      3'd5:       chr_page = chr_bank_q[R3];
      3'd6:       chr_page = chr_bank_q[R4];
      default:    chr_page = chr_bank_q[R5];
    endcase
  end

  assign mirror   = mirror_q;
  assign wram_ctl = wram_ctl_q;

  logic unused_bits;
  assign unused_bits = ^{cpu_addr[12:1], chr_bank_q[R0][0], chr_bank_q[R1][0]};

`ifdef N108_SCANLINE_IRQ_EN
  logic       a12_rise, irq_wr, edge_live;
  logic [7:0] latch_q, latch_d, counter_q, counter_d;
  logic       reload_q, reload_d, irq_en_q, irq_en_d, irq_q, irq_d;

  n108_a12_filter #(
    .A12_FILT(A12_FILT)
  ) u_a12_filter (
    .clk     (clk),
    .rst_n   (rst_n),
    .a12     (ppu_addr[2]),
    .a12_rise(a12_rise)
  );

  // Counter-affecting writes take priority; a coincident edge is dropped.
  assign irq_wr    = wr_en & (((win == WinIrqLatch) & odd) | (win == WinIrqCtl));
  assign edge_live = a12_rise & ~irq_wr;

  always_comb begin
    latch_d   = latch_q;
    counter_d = counter_q;
    reload_d  = reload_q;
    irq_en_d  = irq_en_q;
    irq_d     = irq_q;
    if (edge_live) begin
      if (counter_q == 8'd0 || reload_q) begin
        counter_d = latch_q;
        reload_d  = 1'b0;
      end else begin
        counter_d = counter_q - 8'd1;
      end
      if (counter_d == 8'd0 && irq_en_q) irq_d = 1'b1;
    end
    if (wr_en) begin
      case (win)
        WinIrqLatch: begin
          if (!odd) begin
            latch_d = cpu_data;
          end else begin
            reload_d  = 1'b1;
            counter_d = 8'd0;
          end
        end
        WinIrqCtl: begin
          if (!odd) begin
            irq_en_d = 1'b0;
            irq_d    = 1'b0;
          end else begin
            irq_en_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_q   <= '0;
      counter_q <= '0;
      reload_q  <= 1'b0;
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      latch_q   <= latch_d;
      counter_q <= counter_d;
      reload_q  <= reload_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_n108_bank_core.sv
// Scoreboard bench for n108_bank_core: directed register/IRQ scenarios plus random traffic.
module tb_n108_bank_core;

  localparam int unsigned PRG_W    = 6;
  localparam int unsigned CHR_W    = 8;
  localparam int unsigned A12_FILT = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cpu_we = 1'b0;
  logic [15:0]      cpu_addr = 16'h8000;
  logic [7:0]       cpu_data = 8'h00;
  logic [2:0]       ppu_addr = 3'b000;
  logic [PRG_W-1:0] prg_page;
  logic [CHR_W-1:0] chr_page;
  logic             mirror;
  logic [1:0]       wram_ctl;
  logic             irq;

  n108_bank_core #(
    .PRG_W   (PRG_W),
    .CHR_W   (CHR_W),
    .A12_FILT(A12_FILT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cpu_we  (cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_data(cpu_data),
    .ppu_addr(ppu_addr),
    .prg_page(prg_page),
    .chr_page(chr_page),
    .mirror  (mirror),
    .wram_ctl(wram_ctl),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [PRG_W-1:0] prg;
    logic [CHR_W-1:0] chr;
    logic             mir;
    logic [1:0]       wram;
    logic             irq;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Behavioural model of the mapper's visible state.
  int m_bank[8];
  int m_idx, m_wram, m_latch, m_cnt, m_low;
  bit m_mode, m_inv, m_mir, m_reload, m_irq_en, m_irq, m_prev;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_bank[i] = 0;
    m_idx = 0; m_wram = 0; m_latch = 0; m_cnt = 0; m_low = 0;
    m_mode = 0; m_inv = 0; m_mir = 0; m_reload = 0; m_irq_en = 0; m_irq = 0; m_prev = 0;
  endtask

  function automatic int exp_prg(logic [15:0] a);
    int last = (1 << PRG_W) - 1;
    int pages[4];
    pages[0] = m_mode ? last - 1 : m_bank[6];
    pages[1] = m_bank[7];
    pages[2] = m_mode ? m_bank[6] : last - 1;
    pages[3] = last;
    return pages[int'(a[14:13])];
  endfunction

  function automatic int exp_chr(logic [2:0] p);
    int q = int'(p) ^ (m_inv ? 4 : 0);
    if (q < 2) return (m_bank[0] & ~1) | (q & 1);
    if (q < 4) return (m_bank[1] & ~1) | (q & 1);
    return m_bank[q - 2];
  endfunction

  // Applies the rules at one rising clk edge using the inputs held during the cycle.
  task automatic model_clock();
    bit wr, odd;
    int win;
`ifdef N108_SCANLINE_IRQ_EN
    bit a12, rise, cancel;
`endif
    if (!rst_n) return;
    wr  = cpu_we && cpu_addr[15];
    win = int'(cpu_addr[14:13]);
    odd = cpu_addr[0];
`ifdef N108_SCANLINE_IRQ_EN
    a12    = ppu_addr[2];
    rise   = a12 && !m_prev && m_low >= A12_FILT;
    m_low  = a12 ? 0 : (m_low < 1000 ? m_low + 1 : m_low);
    m_prev = a12;
    cancel = wr && ((win == 2 && odd) || win == 3);
    if (rise && !cancel) begin
      if (m_cnt == 0 || m_reload) begin
        m_cnt    = m_latch;
        m_reload = 0;
      end else begin
        m_cnt = m_cnt - 1;
      end
      if (m_cnt == 0 && m_irq_en) m_irq = 1;
    end
`endif
    if (wr) begin
      case (win)
        0: if (!odd) begin
             m_idx  = int'(cpu_data[2:0]);
             m_mode = cpu_data[6];
             m_inv  = cpu_data[7];
           end else begin
             m_bank[m_idx] = int'(cpu_data) % (1 << (m_idx < 6 ? CHR_W : PRG_W));
           end
        1: if (!odd) m_mir = cpu_data[0];
           else      m_wram = int'(cpu_data[7:6]);
`ifdef N108_SCANLINE_IRQ_EN
        2: if (!odd) m_latch = int'(cpu_data);
           else begin
             m_reload = 1;
             m_cnt    = 0;
           end
        3: if (!odd) begin
             m_irq_en = 0;
             m_irq    = 0;
           end else begin
             m_irq_en = 1;
           end
`endif
        default: ;
      endcase
    end
  endtask

  task automatic push(string nm);
    exp_t e;
    e.name = nm;
    e.prg  = PRG_W'(exp_prg(cpu_addr));
    e.chr  = CHR_W'(exp_chr(ppu_addr));
    e.mir  = m_mir;
    e.wram = 2'(m_wram);
    e.irq  = m_irq;
    sb_q.push_back(e);
  endtask

  // One cycle: drive, queue the expectation for this cycle, then advance the model over the edge.
  task automatic step(bit we, logic [15:0] addr, logic [7:0] data, bit a12, string nm);
    cpu_we   = we;
    cpu_addr = addr;
    cpu_data = data;
    ppu_addr = {a12, 2'($urandom)};
    push(nm);
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(bit a12, string nm);
    step(1'b0, 16'h8000 | 16'($urandom), 8'h00, a12, nm);
  endtask

  task automatic wr(logic [15:0] addr, logic [7:0] data, string nm);
    step(1'b1, addr, data, 1'b0, nm);
  endtask

  task automatic pulse(int lows, string nm);
    repeat (lows) idle(1'b0, nm);
    idle(1'b1, nm);
  endtask

  task automatic read_at(logic [15:0] addr, logic [2:0] ppu, string nm);
    cpu_we   = 1'b0;
    cpu_addr = addr;
    cpu_data = 8'h00;
    ppu_addr = ppu;
    push(nm);
    model_clock();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      checks++;
      if ({prg_page, chr_page, mirror, wram_ctl, irq} !==
          {mon_e.prg, mon_e.chr, mon_e.mir, mon_e.wram, mon_e.irq}) begin
        errors++;
        $display("FAIL %s: got prg=%0d chr=%0d mirror=%0b wram=%0b irq=%0b, want prg=%0d chr=%0d mirror=%0b wram=%0b irq=%0b",
                 mon_e.name, prg_page, chr_page, mirror, wram_ctl, irq,
                 mon_e.prg, mon_e.chr, mon_e.mir, mon_e.wram, mon_e.irq);
      end
    end
  end

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    read_at(16'h8000, 3'b000, "reset_8000");
    read_at(16'hE000, 3'b111, "reset_e000");
    rst_n = 1'b1;

    // PRG mapping, both modes
    wr(16'h8000, 8'h06, "sel_r6");
    wr(16'h8001, 8'h05, "r6_5");
    wr(16'h8000, 8'h07, "sel_r7");
    wr(16'h8001, 8'h09, "r7_9");
    read_at(16'h8000, 3'b000, "prg_m0_s0");
    read_at(16'hA000, 3'b000, "prg_m0_s1");
    read_at(16'hC000, 3'b000, "prg_m0_s2");
    read_at(16'hE000, 3'b000, "prg_m0_s3");
    wr(16'h8000, 8'h46, "sel_mode1");
    read_at(16'h8000, 3'b000, "prg_m1_s0");
    read_at(16'hC000, 3'b000, "prg_m1_s2");

    // CHR inversion and 2 KB pair bit0 substitution
    wr(16'h8000, 8'h80, "sel_inv_r0");
    wr(16'h8001, 8'h10, "r0_10");
    read_at(16'h8000, 3'b100, "chr_inv_100");
    read_at(16'h8000, 3'b101, "chr_inv_101");
    for (int i = 2; i < 6; i++) begin
      wr(16'h8000, 8'(i), "sel_chr");
      wr(16'h8001, 8'(8'h20 + i), "chr_bank");
    end
    for (int p = 0; p < 8; p++) read_at(16'h8000, 3'(p), "chr_map");
    wr(16'hA000, 8'h01, "mirror_h");
    wr(16'hA001, 8'hC0, "wram_ctl");
    wr(16'h2000, 8'h00, "ignored_low_addr");
    idle(1'b0, "after_ctl");

    // Random traffic, including ignored writes below $8000
    for (int n = 0; n < 400; n++) begin
      logic [15:0] a;
      logic [7:0]  d;
      bit          we_r;
      a    = 16'($urandom);
      a[15] = ($urandom_range(0, 7) != 0);
      d    = 8'($urandom);
      if (a[14:13] == 2'b10 && !a[0]) d = 8'($urandom_range(0, 3));
      we_r = ($urandom_range(0, 2) == 0);
      step(we_r, a, d, ($urandom_range(0, 3) == 0), "random");
    end

    // Scanline counter: latch=2 fires on the third filtered edge
    wr(16'hE000, 8'h00, "irq_clr");
    wr(16'hC000, 8'h02, "latch_2");
    wr(16'hC001, 8'h00, "reload");
    wr(16'hE001, 8'h00, "irq_en");
    pulse(A12_FILT, "edge1");
    pulse(A12_FILT, "edge2");
    pulse(A12_FILT, "edge3");
    idle(1'b0, "irq_after_edge3");
    idle(1'b0, "irq_hold");
    wr(16'hE000, 8'h00, "irq_ack");
    idle(1'b0, "irq_cleared");

    // Short low run is not counted; write beats a coincident edge
    wr(16'hC000, 8'h01, "latch_1");
    wr(16'hC001, 8'h00, "reload_b");
    wr(16'hE001, 8'h00, "irq_en_b");
    pulse(A12_FILT, "edge_load1");
    pulse(A12_FILT - 1, "short_pulse");
    idle(1'b0, "short_no_irq");
    pulse(A12_FILT, "edge_to_zero");
    idle(1'b0, "irq_b");
    wr(16'hE000, 8'h00, "irq_ack_b");
    wr(16'hE001, 8'h00, "irq_en_c");
    repeat (A12_FILT) idle(1'b0, "pre_coincide");
    step(1'b1, 16'hC001, 8'h00, 1'b1, "c001_on_edge");
    pulse(A12_FILT, "edge_after_reload");
    idle(1'b0, "coincide_result");

    // latch=0 fires on every edge
    wr(16'hC000, 8'h00, "latch_0");
    pulse(A12_FILT, "l0_edge1");
    idle(1'b0, "l0_irq1");
    wr(16'hE000, 8'h00, "l0_ack");
    wr(16'hE001, 8'h00, "l0_en");
    pulse(A12_FILT, "l0_edge2");
    idle(1'b0, "l0_irq2");

    // Reset mid-count with irq high clears everything immediately
    wr(16'hC000, 8'h05, "latch_5");
    wr(16'hC001, 8'h00, "reload_c");
    pulse(A12_FILT, "midcount_edge");
    cpu_we   = 1'b0;
    cpu_addr = 16'hA000;
    ppu_addr = 3'b000;
    #1;
    rst_n = 1'b0;
    model_reset();
    push("async_reset");
    @(posedge clk);
    #1;
    read_at(16'h8000, 3'b010, "in_reset");
    rst_n = 1'b1;
    wr(16'hE001, 8'h00, "post_reset_en");
    pulse(A12_FILT, "post_reset_edge");
    idle(1'b0, "post_reset_irq");
    idle(1'b0, "tail");

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
